// File: rtl/decrypt_input_loader.sv
// decrypt_input_loader
// Collects a 16-byte key and a 16-byte ciphertext block from a byte stream
// and drives them, with a held enable, into a fixed-latency decryption core.
// Optional feature: define LOADER_TIMEOUT_EN to drop partial loads after
// TIMEOUT_CYCLES idle cycles.
//
// Handshake: a byte transfers on a rising clk edge when rx_valid and rx_ready
// are both high. rx_ready is combinational and never depends on rx_valid; it
// is high only in IDLE and only for key bytes, or for data bytes once a
// complete key is held.
module decrypt_input_loader #(
  parameter int DECRYPT_LATENCY = 32,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         rx_is_key,
  output logic         rx_ready,
  output logic [127:0] key,
  output logic [127:0] inputData,
  output logic         decryptEnable,
  output logic         block_done,
  output logic         key_valid,
  output logic [1:0]   o_dbg_state,
  output logic [3:0]   o_dbg_key_cnt,
  output logic [3:0]   o_dbg_data_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int LW = $clog2(DECRYPT_LATENCY + 1);

  logic [1:0]    r_state;
  logic [3:0]    r_key_cnt;
  logic [3:0]    r_data_cnt;
  logic [127:0]  r_key;
  logic [127:0]  r_data;
  logic          r_key_valid;
  logic          r_dec_en;
  logic          r_block_done;
  logic [LW-1:0] r_lat;

  logic          w_ready;
  logic          w_accept;
  logic          w_pending;
  logic          w_timeout;
  logic [6:0]    w_key_base;
  logic [6:0]    w_data_base;

  assign w_ready     = (r_state == IDLE) && (rx_is_key || r_key_valid);
  assign w_accept    = rx_valid && w_ready;
  assign w_pending   = (r_key_cnt != 4'd0) || (r_data_cnt != 4'd0);
  // MSB-first: byte n lands at bit 120 - 8n
  assign w_key_base  = 7'd120 - {r_key_cnt, 3'b000};
  assign w_data_base = 7'd120 - {r_data_cnt, 3'b000};

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle_cnt;

  assign w_timeout = (r_state == IDLE) && w_pending && !w_accept &&
                     (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count consecutive idle cycles while a partial load is pending
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_idle_cnt <= '0;
    end else if ((r_state != IDLE) || !w_pending || w_accept || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Byte assembly, block sequencing and decrypt-enable timing
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_key_cnt    <= 4'd0;
      r_data_cnt   <= 4'd0;
      r_key        <= '0;
      r_data       <= '0;
      r_key_valid  <= 1'b0;
      r_dec_en     <= 1'b0;
      r_block_done <= 1'b0;
      r_lat        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && rx_is_key) begin
            r_key[w_key_base +: 8] <= rx_byte;
            r_key_cnt              <= r_key_cnt + 4'd1;
            if (r_key_cnt == 4'd0)  r_key_valid <= 1'b0;
            if (r_key_cnt == 4'd15) r_key_valid <= 1'b1;
            // A new key invalidates any half-collected ciphertext
            if (r_data_cnt != 4'd0) r_data_cnt <= 4'd0;
          end else if (w_accept) begin
            r_data[w_data_base +: 8] <= rx_byte;
            r_data_cnt               <= r_data_cnt + 4'd1;
            if (r_data_cnt == 4'd15) begin
              r_state  <= RUN;
              r_dec_en <= 1'b1;
              r_lat    <= LW'(DECRYPT_LATENCY - 1);
            end
          end else if (w_timeout) begin
            r_key_cnt  <= 4'd0;
            r_data_cnt <= 4'd0;
          end
        end
        RUN: begin
          if (r_lat == '0) begin
            r_state      <= DONE;
            r_dec_en     <= 1'b0;
            r_block_done <= 1'b1;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        DONE: begin
          r_block_done <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          r_dec_en     <= 1'b0;
          r_block_done <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready       = w_ready;
  assign key            = r_key;
  assign inputData      = r_data;
  assign decryptEnable  = r_dec_en;
  assign block_done     = r_block_done;
  assign key_valid      = r_key_valid;
  assign o_dbg_state    = r_state;
  assign o_dbg_key_cnt  = r_key_cnt;
  assign o_dbg_data_cnt = r_data_cnt;

endmodule

// File: tb/tb_decrypt_input_loader.sv
// Directed bench for decrypt_input_loader: key/data load tables, block timing,
// RUN-state back-pressure, key interruption, mid-RUN reset and idle timeout.
module tb_decrypt_input_loader;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         rx_is_key;
  logic         rx_ready;
  logic [127:0] key;
  logic [127:0] inputData;
  logic         decryptEnable;
  logic         block_done;
  logic         key_valid;
  logic [1:0]   dbg_state;
  logic [3:0]   dbg_key_cnt;
  logic [3:0]   dbg_data_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_key;
    logic [7:0] b;
    logic       exp_rdy;
  } vec_t;

  vec_t vecs[32];

  logic [127:0] key_exp  = 128'h33DE20E331BA5A525AB7C2495A767B5A;
  logic [127:0] data_exp = 128'h67928dd5470d4a11f0ea4ae7d49b2dd4;
  logic [127:0] key2_exp = 128'h11DE20E331BA5A525AB7C2495A767B5A;

  decrypt_input_loader #(.DECRYPT_LATENCY(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .n_rst(n_rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_is_key(rx_is_key), .rx_ready(rx_ready), .key(key),
    .inputData(inputData), .decryptEnable(decryptEnable),
    .block_done(block_done), .key_valid(key_valid),
    .o_dbg_state(dbg_state), .o_dbg_key_cnt(dbg_key_cnt),
    .o_dbg_data_cnt(dbg_data_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Offer one byte for one cycle; rx_ready is checked before the edge
  task automatic offer(input logic [7:0] b, input logic k, input logic exp_rdy, input string nm);
    @(negedge clk);
    rx_byte = b; rx_is_key = k; rx_valid = 1'b1;
    #1 check(nm, 128'(rx_ready), 128'(exp_rdy));
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] kv);
    for (int i = 0; i < 16; i++) offer(kv[127-8*i -: 8], 1'b1, 1'b1, "key_ready");
  endtask

  task automatic load_data(input logic [127:0] dv);
    for (int i = 0; i < 16; i++) offer(dv[127-8*i -: 8], 1'b0, 1'b1, "data_ready");
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_key"}, key, 128'h0);
    check({nm, "_data"}, inputData, 128'h0);
    check({nm, "_en"}, 128'(decryptEnable), 128'h0);
    check({nm, "_done"}, 128'(block_done), 128'h0);
    check({nm, "_kv"}, 128'(key_valid), 128'h0);
    check({nm, "_state"}, 128'(dbg_state), 128'h0);
  endtask

  initial begin : main
    int en_cnt;
    int done_cnt;

    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{1'b1, key_exp[127-8*i -: 8], 1'b1};
      vecs[16 + i] = '{1'b0, data_exp[127-8*i -: 8], 1'b1};
    end

    n_rst = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; rx_is_key = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) n_rst = 1'b1;

    // data byte without a key must be refused
    offer(8'h67, 1'b0, 1'b0, "nokey_ready");
    @(negedge clk);
    check("nokey_data_cnt", 128'(dbg_data_cnt), 128'h0);
    check("nokey_data", inputData, 128'h0);

    // key then data from the table
    for (int i = 0; i < 32; i++) begin
      if (i == 15) check("kv_before_last", 128'(key_valid), 128'h0);
      offer(vecs[i].b, vecs[i].is_key, vecs[i].exp_rdy, vecs[i].is_key ? "tbl_key_ready" : "tbl_data_ready");
      if (i == 15) begin
        @(negedge clk);
        check("kv_after_key", 128'(key_valid), 128'h1);
        check("key_value", key, key_exp);
      end
    end
    // hold rx_valid through RUN
    rx_valid = 1'b1; rx_is_key = 1'b0; rx_byte = 8'hAA;
    check("data_value", inputData, data_exp);
    en_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (decryptEnable) begin
        en_cnt++;
        check("run_ready", 128'(rx_ready), 128'h0);
        check("run_data", inputData, data_exp);
      end
      if (block_done) begin
        done_cnt++;
        check("done_en", 128'(decryptEnable), 128'h0);
        rx_valid = 1'b0;
        break;
      end
    end
    check("en_cycles", 128'(en_cnt), 128'd32);
    check("done_seen", 128'(done_cnt), 128'd1);
    @(negedge clk);
    check("done_pulse_end", 128'(block_done), 128'h0);
    check("back_idle", 128'(dbg_state), 128'h0);
    check("key_kept", key, key_exp);

    // partial block interrupted by a key byte
    for (int i = 0; i < 5; i++) offer(data_exp[127-8*i -: 8], 1'b0, 1'b1, "part_ready");
    @(negedge clk);
    check("part_cnt", 128'(dbg_data_cnt), 128'd5);
    offer(8'h11, 1'b1, 1'b1, "int_key_ready");
    @(negedge clk);
    check("int_data_cnt", 128'(dbg_data_cnt), 128'h0);
    check("int_kv", 128'(key_valid), 128'h0);
    check("int_key_cnt", 128'(dbg_key_cnt), 128'd1);
    for (int i = 0; i < 16; i++) offer(data_exp[127-8*i -: 8], 1'b0, 1'b0, "rej_ready");
    @(negedge clk);
    check("rej_data_cnt", 128'(dbg_data_cnt), 128'h0);
    for (int i = 1; i < 16; i++) offer(key2_exp[127-8*i -: 8], 1'b1, 1'b1, "key2_ready");
    @(negedge clk);
    check("key2_kv", 128'(key_valid), 128'h1);
    check("key2_value", key, key2_exp);
    load_data(data_exp);
    @(negedge clk);
    check("fresh_data", inputData, data_exp);
    check("fresh_en", 128'(decryptEnable), 128'h1);

    // reset in the middle of RUN (first RUN negedge already passed)
    repeat (9) @(negedge clk);
    check("pre_rst_state", 128'(dbg_state), 128'd1);
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk) n_rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (block_done) done_cnt++;
    end
    check("no_done_after_rst", 128'(done_cnt), 128'h0);
    offer(8'h67, 1'b0, 1'b0, "post_rst_ready");

    // idle gap on a partial block
    load_key(key_exp);
    for (int i = 0; i < 3; i++) offer(data_exp[127-8*i -: 8], 1'b0, 1'b1, "gap_ready");
`ifdef LOADER_TIMEOUT_EN
    repeat (254) @(posedge clk);
    @(negedge clk);
    check("gap_254_cnt", 128'(dbg_data_cnt), 128'd3);
    @(negedge clk);
    check("gap_255_cnt", 128'(dbg_data_cnt), 128'h0);
    check("gap_kv", 128'(key_valid), 128'h1);
    load_data(data_exp);
    @(negedge clk);
    check("gap_fresh_data", inputData, data_exp);
    check("gap_fresh_en", 128'(decryptEnable), 128'h1);
`else
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("gap_hold_cnt", 128'(dbg_data_cnt), 128'd3);
    check("gap_hold_kv", 128'(key_valid), 128'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
